// File: rtl/regfile_wb.sv
// regfile_wb: 32x32 MIPS register file, one write port from WB, two bypassed combinational read ports.
// Ports: clk, rst_n (async active-low); rd_addr1/rd_addr2 -> rd_data1/rd_data2 (combinational);
//        wr_en/wr_addr/wr_data commit on rising clk; wr_count counts committed writes (wraps at 256).
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [7:0]        wr_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              commit;
  // Writes to r0 are dropped and never counted; reset also masks the bypass.
  assign commit = rst_n && wr_en && wr_addr != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      wr_count <= '0;
    end else if (commit) begin
      regs[wr_addr] <= wr_data;
      wr_count <= wr_count + 8'd1;
    end
  always_comb begin
    rd_data1 = rd_addr1 == '0 ? '0 : !rst_n ? RESET_VAL : (commit && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
    rd_data2 = rd_addr2 == '0 ? '0 : !rst_n ? RESET_VAL : (commit && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
  end
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed table-driven bench for regfile_wb.
module tb_regfile_wb;
  logic        clk = 1'b0;
  logic        run = 1'b1;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2, wr_addr;
  logic [31:0] rd_data1, rd_data2, wr_data;
  logic        wr_en;
  logic [7:0]  wr_count;
  int          total = 0;
  int          passed = 0;

  regfile_wb dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_count(wr_count)
  );

  always #5 if (run) clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [7:0]  ec;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk)
    if (rst_n === 1'b1 && wr_en === 1'b1 && ($isunknown(wr_addr) || $isunknown(wr_data))) begin
      total++;
      $display("FAIL x_on_write: addr %h data %h", wr_addr, wr_data);
    end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv [9];
    tv[0] = '{1'b1, 5'd11, 32'hDDDDDDDD, 5'd11, 5'd0,  32'hDDDDDDDD, 32'h0,        8'd0};
    tv[1] = '{1'b0, 5'd11, 32'h00000000, 5'd11, 5'd12, 32'hDDDDDDDD, 32'h0,        8'd1};
    tv[2] = '{1'b1, 5'd17, 32'hA5A5A5A5, 5'd17, 5'd17, 32'hA5A5A5A5, 32'hA5A5A5A5, 8'd1};
    tv[3] = '{1'b0, 5'd17, 32'h12345678, 5'd17, 5'd11, 32'hA5A5A5A5, 32'hDDDDDDDD, 8'd2};
    tv[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        8'd2};
    tv[5] = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd17, 32'h0,        32'hA5A5A5A5, 8'd2};
    tv[6] = '{1'b1, 5'd11, 32'h11110000, 5'd11, 5'd17, 32'h11110000, 32'hA5A5A5A5, 8'd2};
    tv[7] = '{1'b1, 5'd31, 32'hCAFEBABE, 5'd11, 5'd31, 32'h11110000, 32'hCAFEBABE, 8'd3};
    tv[8] = '{1'b0, 5'd31, 32'h00000000, 5'd31, 5'd11, 32'hCAFEBABE, 32'h11110000, 8'd4};
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    #1;
    chk("reset_count", {24'h0, wr_count}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #0.1;
      chk("reset_rd1", rd_data1, 32'h0);
      chk("reset_rd2", rd_data2, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wr_en = tv[i].we;
      wr_addr = tv[i].wa;
      wr_data = tv[i].wd;
      rd_addr1 = tv[i].r1;
      rd_addr2 = tv[i].r2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rd_data1, tv[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd_data2, tv[i].e2);
      chk($sformatf("vec%0d_cnt", i), {24'h0, wr_count}, {24'h0, tv[i].ec});
      @(posedge clk);
      #1;
    end
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    wr_en = 1'b0;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd20;
    #1;
    chk("load_rd3", rd_data1, 32'd3);
    chk("load_rd20", rd_data2, 32'd20);
    chk("load_cnt", {24'h0, wr_count}, 32'd35);
    @(negedge clk);
    run = 1'b0;
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hDEADBEEF;
    #1;
    chk("prereset_bypass", rd_data1, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("midreset_cnt", {24'h0, wr_count}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #0.1;
      chk("midreset_rd1", rd_data1, 32'h0);
      chk("midreset_rd2", rd_data2, 32'h0);
    end
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd20;
    #1;
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_edge_cnt", {24'h0, wr_count}, 32'h0);
    chk("reset_edge_rd3", rd_data1, 32'h0);
    wr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("postreset_rd3", rd_data1, 32'h0);
    chk("postreset_rd20", rd_data2, 32'h0);
    chk("postreset_cnt", {24'h0, wr_count}, 32'h0);
    rd_addr1 = 5'd16;
    for (int i = 0; i < 256; i++) begin
      wr(5'd16, 32'(i));
      if (i == 254) chk("cnt_255", {24'h0, wr_count}, 32'd255);
    end
    wr_en = 1'b0;
    #1;
    chk("wrap_cnt", {24'h0, wr_count}, 32'h0);
    chk("wrap_rd16", rd_data1, 32'd255);
    for (int i = 0; i < 3; i++) begin
      wr_data = $urandom;
      @(posedge clk);
      #1;
      chk("idle_rd16", rd_data1, 32'd255);
      chk("idle_cnt", {24'h0, wr_count}, 32'h0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
